// File: rtl/rf_write_arbiter_if.sv
// Two-requester write port bundle for rf_write_arbiter.
// Requesters drive the master side; the arbiter is the slave.
interface rf_write_arbiter_if #(
  parameter int Dbits = 32
);
  logic             req0_valid;
  logic             req0_ready;
  logic [4:0]       req0_addr;
  logic [Dbits-1:0] req0_data;
  logic             req1_valid;
  logic             req1_ready;
  logic [4:0]       req1_addr;
  logic [Dbits-1:0] req1_data;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Register-file write arbiter: zero-fills every location after reset, then
// grants one of two requesters per cycle, alternating under contention.
module rf_write_arbiter #(
  parameter int Nloc  = 32,
  parameter int Dbits = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  rf_write_arbiter_if.slave req,
  output logic             wr,
  output logic [4:0]       WriteAddr,
  output logic [Dbits-1:0] WriteData,
  output logic             init_done,
  output logic             fsm_state
);

  localparam int CW = (Nloc > 1) ? $clog2(Nloc) : 1;

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  state_t        state, next_state;
  logic [CW-1:0] clr_idx;
  logic          clr_last;
  logic          last_grant;
  logic          ready0, ready1;
  logic          take0, take1;

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // valid never waits on ready; a stalled requester keeps addr/data stable,
  // and ready is a same-cycle function of both valids and last_grant.

  assign clr_last  = (clr_idx == CW'(Nloc - 1));
  assign fsm_state = state;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= CLEAR;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    ready0     = 1'b0;
    ready1     = 1'b0;
    case (state)
      CLEAR: if (clr_last) next_state = RUN;
      RUN: begin
        // last_grant==1 means requester 1 won last, so requester 0 wins a tie
        ready0 = req.req0_valid && (!req.req1_valid || last_grant);
        ready1 = req.req1_valid && (!req.req0_valid || !last_grant);
      end
      default: next_state = CLEAR;
    endcase
  end

  assign req.req0_ready = ready0;
  assign req.req1_ready = ready1;
  assign take0          = ready0 && req.req0_valid;
  assign take1          = ready1 && req.req1_valid;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr         <= 1'b0;
      WriteAddr  <= 5'd0;
      WriteData  <= '0;
      init_done  <= 1'b0;
      clr_idx    <= '0;
      last_grant <= 1'b1;
    end else if (state == CLEAR) begin
      wr        <= 1'b1;
      WriteAddr <= 5'(clr_idx);
      WriteData <= '0;
      if (clr_last) init_done <= 1'b1;
      else          clr_idx   <= clr_idx + CW'(1);
    end else if (take0) begin
      // register 0 is hard-wired to zero, so its handshake completes silently
      wr         <= (req.req0_addr != 5'd0);
      WriteAddr  <= req.req0_addr;
      WriteData  <= req.req0_data;
      last_grant <= 1'b0;
    end else if (take1) begin
      wr         <= (req.req1_addr != 5'd0);
      WriteAddr  <= req.req1_addr;
      WriteData  <= req.req1_data;
      last_grant <= 1'b1;
    end else begin
      wr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: clear sweep, arbitration, address zero,
// backpressure and reset behaviour, each with hand-computed expectations.
module tb_rf_write_arbiter;

  localparam int Nloc  = 32;
  localparam int Dbits = 32;

  logic             clock;
  logic             reset_n;
  logic             wr;
  logic [4:0]       WriteAddr;
  logic [Dbits-1:0] WriteData;
  logic             init_done;
  logic             fsm_state;

  int errors = 0;
  int checks = 0;

  rf_write_arbiter_if #(.Dbits(Dbits)) bus ();

  rf_write_arbiter #(.Nloc(Nloc), .Dbits(Dbits)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req       (bus.slave),
    .wr        (wr),
    .WriteAddr (WriteAddr),
    .WriteData (WriteData),
    .init_done (init_done),
    .fsm_state (fsm_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 1'b0;
    bus.req0_addr  = 5'd0;
    bus.req0_data  = '0;
    bus.req1_valid = 1'b0;
    bus.req1_addr  = 5'd0;
    bus.req1_data  = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #12;
    checks++;
    if (wr !== 1'b0) begin errors++; $display("FAIL reset_wr: got %b want 0", wr); end
    checks++;
    if (WriteAddr !== 5'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", WriteAddr); end
    checks++;
    if (WriteData !== 32'd0) begin errors++; $display("FAIL reset_data: got %h want 0", WriteData); end
    checks++;
    if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done: got %b want 0", init_done); end
    checks++;
    if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got %b%b want 00", bus.req0_ready, bus.req1_ready);
    end
    checks++;
    if (fsm_state !== 1'b0) begin errors++; $display("FAIL reset_state: got %b want 0", fsm_state); end
  endtask

  // Expects reset_n just released mid-cycle; checks all Nloc sweep writes.
  task automatic run_sweep(input string tag);
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    for (int i = 0; i < Nloc; i++) begin
      checks++;
      if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s_ready[%0d]: got %b%b want 00", tag, i, bus.req0_ready, bus.req1_ready);
      end
      tick();
      checks++;
      if (wr !== 1'b1 || WriteAddr !== 5'(i) || WriteData !== 32'd0) begin
        errors++;
        $display("FAIL %s_write[%0d]: got wr=%b addr=%0d data=%h want wr=1 addr=%0d data=0",
                 tag, i, wr, WriteAddr, WriteData, i);
      end
      checks++;
      if (init_done !== (i == Nloc - 1)) begin
        errors++;
        $display("FAIL %s_init_done[%0d]: got %b want %b", tag, i, init_done, (i == Nloc - 1));
      end
    end
    idle_inputs();
    checks++;
    if (fsm_state !== 1'b1) begin errors++; $display("FAIL %s_state: got %b want 1", tag, fsm_state); end
    tick();
    checks++;
    if (wr !== 1'b0) begin errors++; $display("FAIL %s_idle_wr: got %b want 0", tag, wr); end
  endtask

  task automatic test_clear_sweep();
    reset_n = 1'b1;
    run_sweep("sweep");
  endtask

  // last_grant is requester 1 out of reset, so order is 0,1,0,1
  task automatic test_contention();
    logic [4:0]  a0, a1;
    logic [31:0] d0, d1;
    int g;
    a0 = 5'd10; d0 = 32'hA000_0010;
    a1 = 5'd20; d1 = 32'hB000_0020;
    for (int k = 0; k < 4; k++) begin
      g = k % 2;
      bus.req0_valid = 1'b1; bus.req0_addr = a0; bus.req0_data = d0;
      bus.req1_valid = 1'b1; bus.req1_addr = a1; bus.req1_data = d1;
      #1;
      checks++;
      if (bus.req0_ready !== (g == 0) || bus.req1_ready !== (g == 1)) begin
        errors++;
        $display("FAIL contend_ready[%0d]: got %b%b want %b%b", k,
                 bus.req0_ready, bus.req1_ready, (g == 0), (g == 1));
      end
      tick();
      checks++;
      if (wr !== 1'b1 || WriteAddr !== ((g == 0) ? a0 : a1) || WriteData !== ((g == 0) ? d0 : d1)) begin
        errors++;
        $display("FAIL contend_write[%0d]: got wr=%b addr=%0d data=%h want wr=1 addr=%0d data=%h",
                 k, wr, WriteAddr, WriteData, (g == 0) ? a0 : a1, (g == 0) ? d0 : d1);
      end
      if (g == 0) begin a0 = a0 + 5'd1; d0 = d0 + 32'd1; end
      else        begin a1 = a1 + 5'd1; d1 = d1 + 32'd1; end
    end
    idle_inputs();
    #1;
    tick();
    checks++;
    if (wr !== 1'b0 || WriteAddr !== 5'd21 || WriteData !== 32'hB000_0021) begin
      errors++;
      $display("FAIL contend_hold: got wr=%b addr=%0d data=%h want wr=0 addr=21 data=b0000021",
               wr, WriteAddr, WriteData);
    end
  endtask

  task automatic test_single();
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd5; bus.req0_data = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_ready: got %b%b want 10", bus.req0_ready, bus.req1_ready);
    end
    tick();
    idle_inputs();
    checks++;
    if (wr !== 1'b1 || WriteAddr !== 5'd5 || WriteData !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL single_write: got wr=%b addr=%0d data=%h want wr=1 addr=5 data=deadbeef",
               wr, WriteAddr, WriteData);
    end
    tick();
    checks++;
    if (wr !== 1'b0 || WriteAddr !== 5'd5 || WriteData !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL single_hold: got wr=%b addr=%0d data=%h want wr=0 addr=5 data=deadbeef",
               wr, WriteAddr, WriteData);
    end
  endtask

  task automatic test_addr_zero();
    bus.req1_valid = 1'b1; bus.req1_addr = 5'd0; bus.req1_data = 32'h5555_5555;
    #1;
    checks++;
    if (bus.req1_ready !== 1'b1 || bus.req0_ready !== 1'b0) begin
      errors++;
      $display("FAIL addr0_ready: got %b%b want 01", bus.req0_ready, bus.req1_ready);
    end
    tick();
    idle_inputs();
    checks++;
    if (wr !== 1'b0) begin errors++; $display("FAIL addr0_wr: got %b want 0", wr); end
  endtask

  // after the address-zero grant to requester 1, requester 0 wins the tie
  task automatic test_backpressure();
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd7; bus.req0_data = 32'h0000_0077;
    bus.req1_valid = 1'b1; bus.req1_addr = 5'd9; bus.req1_data = 32'h0000_0099;
    #1;
    checks++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_ready_first: got %b%b want 10", bus.req0_ready, bus.req1_ready);
    end
    tick();
    bus.req0_valid = 1'b0;
    checks++;
    if (wr !== 1'b1 || WriteAddr !== 5'd7 || WriteData !== 32'h0000_0077) begin
      errors++;
      $display("FAIL bp_write0: got wr=%b addr=%0d data=%h want wr=1 addr=7 data=77",
               wr, WriteAddr, WriteData);
    end
    #1;
    checks++;
    if (bus.req1_ready !== 1'b1 || bus.req0_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_ready_second: got %b%b want 01", bus.req0_ready, bus.req1_ready);
    end
    tick();
    idle_inputs();
    checks++;
    if (wr !== 1'b1 || WriteAddr !== 5'd9 || WriteData !== 32'h0000_0099) begin
      errors++;
      $display("FAIL bp_write1: got wr=%b addr=%0d data=%h want wr=1 addr=9 data=99",
               wr, WriteAddr, WriteData);
    end
    tick();
    checks++;
    if (wr !== 1'b0) begin errors++; $display("FAIL bp_once: got wr=%b want 0", wr); end
  endtask

  task automatic test_reset_in_run();
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd3; bus.req0_data = 32'h0000_0033;
    tick();
    idle_inputs();
    checks++;
    if (wr !== 1'b1) begin errors++; $display("FAIL run_rst_pre: got wr=%b want 1", wr); end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (wr !== 1'b0 || init_done !== 1'b0 || fsm_state !== 1'b0) begin
      errors++;
      $display("FAIL run_rst_async: got wr=%b init_done=%b state=%b want 0 0 0",
               wr, init_done, fsm_state);
    end
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_mid_sweep_reset();
    for (int i = 0; i <= 17; i++) tick();
    checks++;
    if (wr !== 1'b1 || WriteAddr !== 5'd17) begin
      errors++;
      $display("FAIL mid_pre: got wr=%b addr=%0d want wr=1 addr=17", wr, WriteAddr);
    end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (wr !== 1'b0 || WriteAddr !== 5'd0) begin
      errors++;
      $display("FAIL mid_async: got wr=%b addr=%0d want wr=0 addr=0", wr, WriteAddr);
    end
    tick();
    reset_n = 1'b1;
    run_sweep("resweep");
  endtask

  initial begin
    test_reset();
    test_clear_sweep();
    test_contention();
    test_single();
    test_addr_zero();
    test_backpressure();
    test_reset_in_run();
    test_mid_sweep_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 Parameters SHALL be: Nloc, default 32, number of register locations (2..32); Dbits, default 32, data width.
REQ-002 Port `clock`, input, 1 bit: system clock; all state SHALL update on its rising edge.
REQ-003 Port `reset_n`, input, 1 bit: asynchronous, active-low reset.
REQ-004 Ports `req0_valid` and `req1_valid`, input, 1 bit each: requester n presents a write.
REQ-005 Ports `req0_ready` and `req1_ready`, output, 1 bit each: the arbiter accepts requester n this cycle.
REQ-006 Ports `req0_addr` and `req1_addr`, input, 5 bits each: destination register.
REQ-007 Ports `req0_data` and `req1_data`, input, Dbits each: write data.
REQ-008 Port `wr`, output, 1 bit: register-file write enable.
REQ-009 Port `WriteAddr`, output, 5 bits: register-file write address.
REQ-010 Port `WriteData`, output, Dbits: register-file write data.
REQ-011 Port `init_done`, output, 1 bit: the clear sweep is complete and requesters are being served.

Function
REQ-012 The block SHALL have a two-state FSM, CLEAR and RUN, and SHALL enter CLEAR on reset.
REQ-013 In CLEAR, a counter `clr_idx` SHALL run from 0 to Nloc-1, advancing one step per rising edge; each edge SHALL register wr=1, WriteAddr=clr_idx, WriteData=0.
REQ-014 The edge that registers clr_idx=Nloc-1 SHALL move the FSM to RUN and set init_done=1, so the sweep produces exactly Nloc consecutive write cycles.
REQ-015 In CLEAR, req0_ready and req1_ready SHALL be 0.
REQ-016 In RUN, ready SHALL be combinational and SHALL go to at most one requester per cycle.
REQ-017 Ready selection in RUN SHALL be:
- only one valid: that requester gets ready;
- both valid: the requester not granted most recently gets ready;
- neither valid: both ready=0.
REQ-018 The last-grant pointer SHALL update only on an accepted transfer (valid && ready).
REQ-019 A transfer SHALL occur on a rising edge where valid && ready; on that edge the block SHALL register wr=1, WriteAddr=addr and WriteData=data, giving a one-cycle latency from handshake to the write strobe.
REQ-020 An accepted transfer with addr=0 SHALL complete its handshake but register wr=0, because register 0 is hard-wired to zero.
REQ-021 In RUN, a cycle with no transfer SHALL register wr=0; WriteAddr and WriteData SHALL hold their previous values.
REQ-022 A requester whose valid is asserted without ready SHALL hold addr and data stable, and the arbiter SHALL NOT drop or duplicate its request.
REQ-023 Sustained throughput SHALL be one write per cycle, and with both requesters continuously valid the grants SHALL strictly alternate.
REQ-024 An addr value of Nloc or greater SHALL be passed through unchanged; its effect is undefined at the register file.
REQ-025 `clr_idx` SHALL be wide enough for Nloc-1 and SHALL NOT wrap during the CLEAR state.

Reset
REQ-026 While reset_n=0, asynchronously, the block SHALL force: wr=0, WriteAddr=0, WriteData=0, init_done=0, both ready=0, FSM=CLEAR, clr_idx=0, last-grant pointer=requester 1 (so requester 0 wins the first contention).
REQ-027 Reset asserted mid-CLEAR SHALL restart the sweep at address 0 after release.
REQ-028 Reset asserted in RUN SHALL cancel any registered write immediately (wr=0) and lose any unaccepted request.
REQ-029 The first rising edge after reset_n deasserts SHALL register the CLEAR write to address 0.

Verification
REQ-030 Clear sweep: release reset with Nloc=32 -> wr=1 for 32 consecutive cycles with WriteAddr 0..31 and WriteData=0; init_done rises on the edge that registers address 31; ready stays 0 throughout.
REQ-031 Single requester: req0_valid=1, addr=5, data=0xDEADBEEF, in RUN -> req0_ready=1 the same cycle; the next cycle shows wr=1, WriteAddr=5, WriteData=0xDEADBEEF.
REQ-032 Contention: both valid continuously for 4 cycles with distinct data -> grant order 0,1,0,1; four wr pulses in matching order; no cycle has both ready=1.
REQ-033 Address zero: req1_valid=1, addr=0 -> req1_ready=1, and wr=0 the following cycle.
REQ-034 Backpressure: req1 held valid while req0 wins -> req1 is granted the next cycle with its original addr and data, written exactly once.
REQ-035 Mid-sweep reset: pulse reset_n low at clr_idx=17 -> wr drops to 0 asynchronously; after release the sweep restarts at address 0 and runs a full 32 cycles.
